// File: rtl/level_timer_ctrl.sv
// Game-flow sequencer for the scoreboard overlay: level number, per-level target,
// BCD countdown timer and win/loss decision at timeout.
module level_timer_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int LEVEL_TIME_S = 60,
    parameter int INTRO_S      = 2,
    parameter int NUM_LEVELS   = 5,
    parameter int TARGET_BASE  = 650,
    parameter int TARGET_STEP  = 350
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_game,
    input  logic        pause,
    input  logic [13:0] score,
    output logic [2:0]  level_num,
    output logic [13:0] target,
    output logic [3:0]  tens_timer,
    output logic [3:0]  units_timer,
    output logic [2:0]  game_state,
    output logic        play_active,
    output logic        score_clear,
    output logic        level_done
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INTRO     = 3'd1;
    localparam logic [2:0] ST_PLAYING   = 3'd2;
    localparam logic [2:0] ST_LEVEL_WIN = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;
    localparam logic [2:0] ST_GAME_WON  = 3'd5;

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [3:0]      TENS_INIT   = 4'(LEVEL_TIME_S / 10);
    localparam logic [3:0]      UNITS_INIT  = 4'(LEVEL_TIME_S % 10);
    localparam logic [3:0]      INTRO_LAST  = 4'(INTRO_S);
    localparam logic [2:0]      LEVEL_LAST  = 3'(NUM_LEVELS);
    localparam logic [13:0]     TARGET_INIT = 14'(TARGET_BASE);
    localparam logic [14:0]     TARGET_MAX  = 15'd9999;

    logic [2:0]    state_q, state_d;
    logic [2:0]    level_q, level_d;
    logic [13:0]   target_q, target_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    intro_q, intro_d;
    logic          score_clear_q, score_clear_d;
    logic          level_done_q, level_done_d;

    logic          run;
    logic          tick;
    logic [14:0]   target_sum;

    always_comb begin
        run        = (state_q == ST_INTRO) || ((state_q == ST_PLAYING) && !pause);
        tick       = run && (presc_q == PRESC_MAX);
        target_sum = {1'b0, target_q} + 15'(TARGET_STEP);

        state_d       = state_q;
        level_d       = level_q;
        target_d      = target_q;
        tens_d        = tens_q;
        units_d       = units_q;
        presc_d       = presc_q;
        intro_d       = intro_q;
        score_clear_d = 1'b0;
        level_done_d  = 1'b0;

        if (run) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                level_d  = 3'd1;
                target_d = TARGET_INIT;
                tens_d   = TENS_INIT;
                units_d  = UNITS_INIT;
                if (start_game) begin
                    state_d       = ST_INTRO;
                    score_clear_d = 1'b1;
                    presc_d       = '0;
                    intro_d       = '0;
                end
            end
            ST_INTRO: begin
                if (tick) begin
                    if (intro_q + 4'd1 == INTRO_LAST) begin
                        state_d = ST_PLAYING;
                        intro_d = '0;
                        presc_d = '0;
                    end else begin
                        intro_d = intro_q + 4'd1;
                    end
                end
            end
            ST_PLAYING: begin
                if (tick && !((tens_q == 4'd0) && (units_q == 4'd0))) begin
                    if (units_q != 4'd0) begin
                        units_d = units_q - 4'd1;
                    end else begin
                        units_d = 4'd9;
                        tens_d  = tens_q - 4'd1;
                    end
                    // the decrement that lands on 00 also decides the level outcome
                    if ((tens_q == 4'd0) && (units_q == 4'd1)) begin
                        if (score >= target_q) begin
                            state_d      = ST_LEVEL_WIN;
                            level_done_d = 1'b1;
                        end else begin
                            state_d = ST_GAME_OVER;
                        end
                    end
                end
            end
            ST_LEVEL_WIN: begin
                if (level_q == LEVEL_LAST) begin
                    state_d = ST_GAME_WON;
                end else begin
                    level_d  = level_q + 3'd1;
                    target_d = (target_sum > TARGET_MAX) ? TARGET_MAX[13:0] : target_sum[13:0];
                    tens_d   = TENS_INIT;
                    units_d  = UNITS_INIT;
                    state_d  = ST_INTRO;
                    presc_d  = '0;
                    intro_d  = '0;
                end
            end
            ST_GAME_OVER, ST_GAME_WON: begin
                if (start_game) begin
                    state_d       = ST_INTRO;
                    score_clear_d = 1'b1;
                    level_d       = 3'd1;
                    target_d      = TARGET_INIT;
                    tens_d        = TENS_INIT;
                    units_d       = UNITS_INIT;
                    presc_d       = '0;
                    intro_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            level_q       <= 3'd1;
            target_q      <= TARGET_INIT;
            tens_q        <= TENS_INIT;
            units_q       <= UNITS_INIT;
            presc_q       <= '0;
            intro_q       <= '0;
            score_clear_q <= 1'b0;
            level_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            target_q      <= target_d;
            tens_q        <= tens_d;
            units_q       <= units_d;
            presc_q       <= presc_d;
            intro_q       <= intro_d;
            score_clear_q <= score_clear_d;
            level_done_q  <= level_done_d;
        end
    end

    assign level_num   = level_q;
    assign target      = target_q;
    assign tens_timer  = tens_q;
    assign units_timer = units_q;
    assign game_state  = state_q;
    assign score_clear = score_clear_q;
    assign level_done  = level_done_q;
    assign play_active = (state_q == ST_PLAYING) && !pause;

endmodule

// File: doc/level_timer_ctrl.md
Name: level_timer_ctrl

Overview:
- Game-flow sequencer that drives the scoreboard text overlay.
- Owns the level number, the per-level score target and the BCD countdown timer, and decides level win or loss at timeout.
- Runs on the pixel/system clock. Its level_num, target, tens_timer and units_timer outputs connect directly to the scoreboard draw block; score comes from the score accumulator.

Parameters:
TICK_DIV, 50000000, clock cycles per one-second tick (benches override with a small value)
LEVEL_TIME_S, 60, level duration in seconds, legal range 1..99
INTRO_S, 2, seconds spent in the level intro before play starts, legal range 1..15
NUM_LEVELS, 5, number of levels, legal range 1..7
TARGET_BASE, 650, level-1 target score
TARGET_STEP, 350, target increment per level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_game  in  1  one-cycle pulse from the key handler
pause  in  1  level-sensitive; freezes play when high
score  in  14  current cumulative score, binary, 0..9999
level_num  out  3  current level, 1..NUM_LEVELS
target  out  14  current level target, binary
tens_timer  out  4  BCD tens digit of the remaining seconds
units_timer  out  4  BCD units digit of the remaining seconds
game_state  out  3  encoded FSM state: IDLE=0, INTRO=1, PLAYING=2, LEVEL_WIN=3, GAME_OVER=4, GAME_WON=5
play_active  out  1  high when state is PLAYING and pause is low; gates hook and object motion
score_clear  out  1  one-cycle pulse that zeroes the score accumulator
level_done  out  1  one-cycle pulse on a won level

Behaviour:
- Clock and reset: single clk domain. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - level_num = 1
  - target = TARGET_BASE
  - tens_timer/units_timer = LEVEL_TIME_S/10 and LEVEL_TIME_S%10, computed at elaboration
  - prescaler = 0, intro counter = 0
  - score_clear = 0, level_done = 0
- Prescaler:
  - Counts 0..TICK_DIV-1 only in INTRO, and in PLAYING with pause low. Otherwise it holds its value.
  - tick = 1 for one cycle when the count equals TICK_DIV-1; the count then wraps to 0.
  - The prescaler is cleared on every entry to INTRO and to PLAYING.
- IDLE:
  - A start_game pulse moves to INTRO and asserts score_clear for one cycle.
  - level_num = 1, target = TARGET_BASE, timer loaded with LEVEL_TIME_S.
- INTRO:
  - The intro counter increments on each tick.
  - When it reaches INTRO_S, move to PLAYING and clear the intro counter.
  - start_game is ignored.
- PLAYING:
  - On each tick, decrement the BCD timer:
    - units != 0: units - 1.
    - units == 0: units = 9 and tens - 1.
  - The decrement that produces 00 also evaluates the result in the same cycle:
    - score >= target (unsigned, 14 bits): next state LEVEL_WIN, and level_done pulses on the transition.
    - score < target: next state GAME_OVER.
  - The timer never wraps below 00.
  - start_game is ignored.
  - pause high: timer and prescaler frozen, and play_active = 0.
- LEVEL_WIN (lasts exactly 1 cycle):
  - level_num == NUM_LEVELS: go to GAME_WON.
  - Otherwise:
    - level_num + 1.
    - target = min(target + TARGET_STEP, 9999), computed with a 15-bit intermediate.
    - Timer reloaded to LEVEL_TIME_S.
    - Go to INTRO.
  - score is not cleared, because score is cumulative.
- GAME_OVER / GAME_WON:
  - Outputs hold their final values, with the timer showing 00.
  - A start_game pulse asserts score_clear, resets level_num, target and timer to their reset values, and goes to INTRO.
- Simultaneous events:
  - start_game arriving in the same cycle as a tick in INTRO or PLAYING has no effect.
  - pause arriving in the same cycle as a would-be tick suppresses that tick; the prescaler holds at TICK_DIV-1 and fires the tick on the first unpaused cycle.
- Reset mid-operation: outputs return to their reset values immediately and asynchronously. Pending pulses are dropped.
- Output timing: all outputs are registered, except play_active, which is combinational from state and pause.
- Latency: a tick updates the timer digits on the next clock edge.

Test Plan:
- Reset, with TICK_DIV=4 and defaults:
  - Expected: game_state=0, level_num=1, target=650, tens/units=6/0, score_clear=0.
- start_game pulse in IDLE:
  - score_clear is high for exactly 1 cycle, then game_state=1.
  - After 8 cycles, game_state=2 (PLAYING).
  - 4 cycles later the timer reads 5/9; after 10 ticks it reads 5/0; after 11 ticks it reads 4/9.
- score=700 held through the level, timer reaches 00:
  - level_done pulses once, game_state passes through 3 for 1 cycle, then 1.
  - level_num=2, target=1000, timer=6/0, score_clear stays 0.
- score=100 at timeout:
  - game_state=4, timer holds 0/0, level_num unchanged.
- Restart from GAME_OVER:
  - start_game gives a score_clear pulse, level_num=1 and target=650.
- pause held for 10 cycles mid-second:
  - Timer digits and prescaler are frozen and play_active=0.
  - After release, the next tick arrives exactly after the remaining count; a pause asserted on a tick cycle delays that tick.
- Level-win and reset checks:
  - Win at level 5: game_state=5, with no further level increment.
  - NUM_LEVELS=7, TARGET_STEP=2000: the target saturates at 9999.
  - Assert reset asynchronously mid-PLAYING: defaults appear before the next clk edge.
